alarm_datapath: RTL

- Datapath at the other end of the alarm-clock control unit's control bus.
- Executes the control strobes issued by the control unit (Clear, Load_SS, INCR, UPC, Load, LD_DAY_TIME, LD_O_F, Clear_St, SS1:SS0).
- Keeps the running day/hour/minute clock, the alarm time and the alarm-enable flag.
- Returns status (Count, AlarmSet) to the control unit and raises the Alarm output.

---
 rtl/alarm_pkg.sv | 28 ++
 rtl/alarm_if.sv | 39 +++
 rtl/mod_counter.sv | 44 ++++
 rtl/alarm_datapath.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm-clock datapath: default moduli,
// field-select and target encodings.
package alarm_pkg;

    localparam int HOURS_DEF   = 24;
    localparam int MINUTES_DEF = 60;
    localparam int DAYS_DEF    = 7;

    typedef enum logic {
        FS_HOUR = 1'b0,
        FS_MIN  = 1'b1
    } fs_t;

    typedef enum logic [1:0] {
        TGT_CLOCK = 2'd0,
        TGT_ALARM = 2'd1,
        TGT_DAY   = 2'd2
    } tgt_t;

    // SS1 selects the day field and overrides SS0.
    function automatic tgt_t target_of(input logic ss1, input logic ss0);
        if (ss1) begin
            return TGT_DAY;
        end
        return ss0 ? TGT_ALARM : TGT_CLOCK;
    endfunction

endpackage

// File: rtl/alarm_if.sv
// Control/status bus between the alarm-clock control unit (master)
// and the datapath (slave).
interface alarm_if #(
    parameter int WW = 6
);
    logic          Tick;
    logic          Clear;
    logic          Clear_St;
    logic          UPC;
    logic          Load_SS;
    logic          INCR;
    logic          Load;
    logic          LD_DAY_TIME;
    logic          LD_O_F;
    logic          SS0;
    logic          SS1;
    logic          Dismiss;
    logic          Count;
    logic          AlarmSet;
    logic          Alarm;
    logic [2:0]    Day;
    logic [4:0]    Hour;
    logic [5:0]    Minute;
    logic [4:0]    AHour;
    logic [5:0]    AMinute;
    logic [WW-1:0] Work;

    modport master (
        output Tick, Clear, Clear_St, UPC, Load_SS, INCR, Load,
               LD_DAY_TIME, LD_O_F, SS0, SS1, Dismiss,
        input  Count, AlarmSet, Alarm, Day, Hour, Minute, AHour, AMinute, Work
    );

    modport slave (
        input  Tick, Clear, Clear_St, UPC, Load_SS, INCR, Load,
               LD_DAY_TIME, LD_O_F, SS0, SS1, Dismiss,
        output Count, AlarmSet, Alarm, Day, Hour, Minute, AHour, AMinute, Work
    );
endinterface

// File: rtl/mod_counter.sv
// Modulo counter with clear, load and increment; the modulus is an input so
// the same block serves fixed clock fields and the retargetable work register.
module mod_counter #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH:0]   modulus,
    output logic [WIDTH-1:0] value,
    output logic [WIDTH-1:0] value_next,
    output logic             carry
);
    logic [WIDTH-1:0] value_reg;
    logic             at_top;

    // ">=" so a value left over from a larger modulus wraps to zero.
    assign at_top = {1'b0, value_reg} >= (modulus - (WIDTH+1)'(1));
    assign carry  = inc && !clr && !load && at_top;

    always_comb begin
        value_next = value_reg;
        if (clr) begin
            value_next = '0;
        end else if (load) begin
            value_next = load_val;
        end else if (inc) begin
            value_next = at_top ? '0 : value_reg + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_reg <= '0;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value = value_reg;
endmodule

// File: rtl/alarm_datapath.sv
// Alarm-clock datapath: executes control-unit strobes on the work register,
// field selector, running clock, alarm time and alarm flags.
module alarm_datapath
    import alarm_pkg::*;
#(
    parameter int HOURS   = HOURS_DEF,
    parameter int MINUTES = MINUTES_DEF,
    parameter int DAYS    = DAYS_DEF,
    parameter int WW      = 6
) (
    input  logic   Clk,
    input  logic   Reset,
    alarm_if.slave bus
);
    fs_t           fs_reg;
    tgt_t          tgt;
    logic          alarm_set_reg;
    logic          alarm_reg;
    logic [4:0]    ahour_reg;
    logic [5:0]    amin_reg;
    logic [WW-1:0] w_val;
    logic [WW-1:0] w_load_val;
    logic [WW:0]   w_mod;
    logic [WW-1:0] unused_w_next;
    logic          unused_w_carry;
    logic [2:0]    day_val;
    logic [2:0]    day_wr;
    logic [2:0]    unused_day_next;
    logic          unused_day_carry;
    logic [4:0]    hour_val, hour_next, hour_wr;
    logic [5:0]    min_val, min_next, min_wr;
    logic          min_carry, hour_carry;
    logic          clk_load, alm_load, tick_eff, alarm_off, alarm_match;

    assign tgt      = target_of(bus.SS1, bus.SS0);
    assign clk_load = bus.Load && (tgt == TGT_CLOCK);
    assign alm_load = bus.Load && (tgt == TGT_ALARM);
    // A tick that coincides with a clock write is discarded whole.
    assign tick_eff = bus.Tick && !clk_load && !bus.LD_DAY_TIME;

    // Writes take the pre-edge W, folded into the destination range.
    assign hour_wr = 5'(32'(w_val[4:0]) % HOURS);
    assign min_wr  = 6'(32'(w_val) % MINUTES);
    assign day_wr  = 3'(32'(w_val[2:0]) % DAYS);

    always_comb begin
        w_mod      = (WW+1)'(HOURS);
        w_load_val = '0;
        case (tgt)
            TGT_DAY: begin
                w_mod      = (WW+1)'(DAYS);
                w_load_val = WW'(day_val);
            end
            TGT_ALARM: begin
                w_mod      = (fs_reg == FS_MIN) ? (WW+1)'(MINUTES) : (WW+1)'(HOURS);
                w_load_val = (fs_reg == FS_MIN) ? WW'(amin_reg) : WW'(ahour_reg);
            end
            default: begin
                w_mod      = (fs_reg == FS_MIN) ? (WW+1)'(MINUTES) : (WW+1)'(HOURS);
                w_load_val = (fs_reg == FS_MIN) ? WW'(min_val) : WW'(hour_val);
            end
        endcase
    end

    mod_counter #(.WIDTH(WW)) u_work (
        .clk(Clk), .rst_n(Reset), .clr(bus.Clear), .load(bus.Load_SS), .inc(bus.INCR),
        .load_val(w_load_val), .modulus(w_mod),
        .value(w_val), .value_next(unused_w_next), .carry(unused_w_carry)
    );

    mod_counter #(.WIDTH(6)) u_minute (
        .clk(Clk), .rst_n(Reset), .clr(1'b0), .load(clk_load && (fs_reg == FS_MIN)),
        .inc(tick_eff), .load_val(min_wr), .modulus(7'(MINUTES)),
        .value(min_val), .value_next(min_next), .carry(min_carry)
    );

    mod_counter #(.WIDTH(5)) u_hour (
        .clk(Clk), .rst_n(Reset), .clr(1'b0), .load(clk_load && (fs_reg == FS_HOUR)),
        .inc(min_carry), .load_val(hour_wr), .modulus(6'(HOURS)),
        .value(hour_val), .value_next(hour_next), .carry(hour_carry)
    );

    mod_counter #(.WIDTH(3)) u_day (
        .clk(Clk), .rst_n(Reset), .clr(1'b0), .load(bus.LD_DAY_TIME),
        .inc(hour_carry), .load_val(day_wr), .modulus(4'(DAYS)),
        .value(day_val), .value_next(unused_day_next), .carry(unused_day_carry)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fs_reg    <= FS_HOUR;
            ahour_reg <= '0;
            amin_reg  <= '0;
        end else begin
            if (bus.Clear || bus.Clear_St) begin
                fs_reg <= FS_HOUR;
            end else if (bus.UPC) begin
                fs_reg <= (fs_reg == FS_HOUR) ? FS_MIN : FS_HOUR;
            end
            if (alm_load) begin
                if (fs_reg == FS_MIN) begin
                    amin_reg <= min_wr;
                end else begin
                    ahour_reg <= hour_wr;
                end
            end
        end
    end

    // Match against the post-tick time; the alarm-time registers are pre-edge.
    assign alarm_match = tick_eff && alarm_set_reg &&
                         (hour_next == ahour_reg) && (min_next == amin_reg);
    assign alarm_off   = bus.LD_O_F && alarm_set_reg;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            alarm_set_reg <= 1'b0;
            alarm_reg     <= 1'b0;
        end else begin
            if (bus.LD_O_F) begin
                alarm_set_reg <= ~alarm_set_reg;
            end
            if (bus.Dismiss || alarm_off) begin
                alarm_reg <= 1'b0;
            end else if (alarm_match) begin
                alarm_reg <= 1'b1;
            end
        end
    end

    assign bus.Count    = (fs_reg == FS_MIN);
    assign bus.AlarmSet = alarm_set_reg;
    assign bus.Alarm    = alarm_reg;
    assign bus.Day      = day_val;
    assign bus.Hour     = hour_val;
    assign bus.Minute   = min_val;
    assign bus.AHour    = ahour_reg;
    assign bus.AMinute  = amin_reg;
    assign bus.Work     = w_val;
endmodule
